// File: rtl/i2c_bus_arbiter.sv
// Two-client arbiter for one i2c_master_multibyte: whole-transaction ownership,
// round-robin on contention, owner-only control muxing and a grant watchdog.
module i2c_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 1024,
    parameter int unsigned TO_W          = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c0_req,
    output logic       c0_grant,
    input  logic       c0_start,
    input  logic       c0_stop,
    input  logic       c0_data_valid,
    input  logic [7:0] c0_data,
    output logic       c0_data_req,
    output logic       c0_busy,
    input  logic       c1_req,
    output logic       c1_grant,
    input  logic       c1_start,
    input  logic       c1_stop,
    input  logic       c1_data_valid,
    input  logic [7:0] c1_data,
    output logic       c1_data_req,
    output logic       c1_busy,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_data_valid,
    output logic [7:0] m_data,
    input  logic       m_data_req,
    input  logic       m_busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_DRAIN,
        S_HOLDOFF
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_grant, w_grant_nxt;
    logic            r_last, w_last_nxt;
    logic            r_seen, w_seen_nxt;
    logic            r_to, w_to_nxt;
    logic [TO_W-1:0] r_cnt, w_cnt_nxt;

    logic       w_req, w_start, w_stop, w_dv;
    logic [7:0] w_data;

    always_comb begin
        w_req   = (r_grant[0] & c0_req)        | (r_grant[1] & c1_req);
        w_start = (r_grant[0] & c0_start)      | (r_grant[1] & c1_start);
        w_stop  = (r_grant[0] & c0_stop)       | (r_grant[1] & c1_stop);
        w_dv    = (r_grant[0] & c0_data_valid) | (r_grant[1] & c1_data_valid);
        w_data  = ({8{r_grant[0]}} & c0_data)  | ({8{r_grant[1]}} & c1_data);
    end

    // Stop and data are held back until the owner has actually started.
    assign m_start      = w_start;
    assign m_stop       = w_stop & (r_state != S_GRANT);
    assign m_data_valid = w_dv   & (r_state != S_GRANT);
    assign m_data       = w_data;

    assign c0_grant    = r_grant[0];
    assign c1_grant    = r_grant[1];
    assign c0_data_req = m_data_req & r_grant[0];
    assign c1_data_req = m_data_req & r_grant[1];
    assign c0_busy     = ~r_grant[0] | m_busy;
    assign c1_busy     = ~r_grant[1] | m_busy;
    assign timeout_err = r_to;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_seen_nxt  = r_seen;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (c0_req | c1_req) begin
                    w_state_nxt = S_GRANT;
                    w_cnt_nxt   = '0;
                    if (c0_req & c1_req)
                        w_grant_nxt = r_last ? 2'b01 : 2'b10;
                    else
                        w_grant_nxt = {c1_req, c0_req};
                end
            end
            S_GRANT: begin
                if (w_start) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (!w_req || r_cnt == TO_W'(GRANT_TIMEOUT - 1)) begin
                    w_state_nxt = S_HOLDOFF;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_grant[1];
                    w_seen_nxt  = 1'b0;
                    w_to_nxt    = w_req;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ACTIVE: begin
                w_seen_nxt = r_seen | m_busy;
                if (w_stop)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Release only once the master has been seen busy and gone idle.
                if (r_seen && !m_busy) begin
                    w_state_nxt = S_HOLDOFF;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_grant[1];
                    w_seen_nxt  = 1'b0;
                end else begin
                    w_seen_nxt = r_seen | m_busy;
                end
            end
            S_HOLDOFF: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 1'b1;
            r_seen  <= 1'b0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_seen  <= w_seen_nxt;
            r_cnt   <= w_cnt_nxt;
            r_to    <= w_to_nxt;
        end
    end

endmodule
